// File: rtl/uart_rx_module_if.sv
// uart_rx_module_if: serial line, configuration and received-word bundle for uart_rx_module.
interface uart_rx_module_if #(
    parameter int DataLength = 9
);
    logic                  Rx;
    logic [3:0]            Speed;
    logic                  Parity;
    logic [DataLength-1:0] Data;
    logic                  DataValid;
    logic                  ParityError;
    logic                  FramingError;
    logic                  Busy;
    modport master (
        output Rx, Speed, Parity,
        input  Data, DataValid, ParityError, FramingError, Busy
    );
    modport slave (
        input  Rx, Speed, Parity,
        output Data, DataValid, ParityError, FramingError, Busy
    );
endinterface

// File: rtl/uart_rx_module.sv
// uart_rx_module: UART receiver (start, DataLength bits LSB first, parity, stop).
// Define UART_RX_START_VERIFY_EN to drop frames whose mid-start-bit sample reads 1.
module uart_rx_module #(
    parameter int DataLength = 9
) (
    input logic              Clock,
    input logic              Reset,
    uart_rx_module_if.slave  bus
);
    localparam int BW = $clog2(DataLength + 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic                  sync1_q, sync2_q;
    logic [3:0]            cnt_q, cnt_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [DataLength-1:0] shift_q, shift_d, data_q, data_d;
    logic                  par_q, par_d;
    logic                  dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, busy_q, busy_d;
    logic [3:0]            n, half;
    logic                  tick_bit, tick_start;
    assign n          = bus.Speed < 4'd2 ? 4'd2 : bus.Speed;
    assign half       = n >> 1;
    assign tick_bit   = cnt_q == n - 4'd1;
    // The counter is cleared on the entry edge, so half-1 lands the start sample floor(N/2) edges later.
    assign tick_start = cnt_q == half - 4'd1;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 4'd1;
        bits_d  = bits_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        pe_d    = pe_q;
        fe_d    = fe_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                bits_d = '0;
                if (!sync2_q) begin
                    state_d = START;
                    busy_d  = 1'b1;
                end
            end
            START: if (tick_start) begin
                cnt_d = '0;
`ifdef UART_RX_START_VERIFY_EN
                state_d = sync2_q ? IDLE : DATA;
                busy_d  = !sync2_q;
`else
                state_d = DATA;
`endif
            end
            DATA: if (tick_bit) begin
                cnt_d   = '0;
                shift_d = {sync2_q, shift_q[DataLength-1:1]};
                bits_d  = bits_q + BW'(1);
                state_d = bits_q == BW'(DataLength - 1) ? PARITY : DATA;
            end
            PARITY: if (tick_bit) begin
                cnt_d   = '0;
                par_d   = sync2_q;
                state_d = STOP;
            end
            STOP: if (tick_bit) begin
                cnt_d   = '0;
                data_d  = shift_q;
                pe_d    = ^shift_q ^ par_q ^ bus.Parity;
                fe_d    = !sync2_q;
                dv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= bus.Rx;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            busy_q  <= busy_d;
        end
    end
    assign bus.Data         = data_q;
    assign bus.DataValid    = dv_q;
    assign bus.ParityError  = pe_q;
    assign bus.FramingError = fe_q;
    assign bus.Busy         = busy_q;
endmodule

// File: tb/tb_uart_rx_module.sv
// tb_uart_rx_module: directed frames checked every cycle against a frame-level timing model.
module tb_uart_rx_module;
    logic Clock = 1'b0;
    logic Reset;
    uart_rx_module_if bus ();
    uart_rx_module dut (.Clock(Clock), .Reset(Reset), .bus(bus.slave));
    always #5 Clock = ~Clock;

    typedef struct {
        int         s;
        int         e;
        bit         has_dv;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;
    exp_t       q[$];
    int         cyc = 0, n_cmp = 0, n_bad = 0, dv_cnt = 0, last_dv_cyc = -1;
    logic [8:0] cap_data = '0;
    logic       cap_pe = 1'b0, cap_fe = 1'b0;
    logic [8:0] exp_data = '0;
    logic       exp_pe = 1'b0, exp_fe = 1'b0;

    function automatic int nper();
        return bus.Speed < 4'd2 ? 2 : int'(bus.Speed);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(posedge Clock);
        #1;
    endtask

    // Frame of 12 bit periods; a 0 stop bit is held only through its sample point.
    task automatic send_frame(input logic [8:0] d, input logic pb, input logic sb, input int abort_at);
        int          n;
        int          h;
        logic [11:0] bits;
        exp_t        x;
        n        = nper();
        h        = n / 2;
        bits     = {sb, pb, d, 1'b0};
        x.s      = cyc + 1;
        x.e      = x.s + 2 + h + 11 * n;
        x.has_dv = 1'b1;
        x.d      = d;
        x.pe     = (^d) ^ pb ^ bus.Parity;
        x.fe     = ~sb;
        q.push_back(x);
        for (int k = 0; k < 12 * n; k++) begin
            if (k == abort_at) begin
                Reset  = 1'b0;
                bus.Rx = 1'b1;
                tick(1);
                Reset  = 1'b1;
                return;
            end
            bus.Rx = (k / n == 11 && !sb && k % n > h) ? 1'b1 : bits[k / n];
            tick(1);
        end
        bus.Rx = 1'b1;
    endtask

    task automatic glitch();
        int   n;
        exp_t x;
        n   = nper();
        x.s = cyc + 1;
`ifdef UART_RX_START_VERIFY_EN
        x.e      = x.s + 2 + n / 2;
        x.has_dv = 1'b0;
        x.d      = '0;
        x.pe     = 1'b0;
        x.fe     = 1'b0;
`else
        x.e      = x.s + 2 + n / 2 + 11 * n;
        x.has_dv = 1'b1;
        x.d      = 9'h1FF;
        x.pe     = (^x.d) ^ 1'b1 ^ bus.Parity;
        x.fe     = 1'b0;
`endif
        q.push_back(x);
        bus.Rx = 1'b0;
        tick(2);
        bus.Rx = 1'b1;
    endtask

    initial begin
        logic r;
        bit   exp_dv, exp_busy;
        forever begin
            @(posedge Clock);
            cyc++;
            r = Reset;
            @(negedge Clock);
            exp_dv = 1'b0;
            if (!r) begin
                q.delete();
                exp_data = '0;
                exp_pe   = 1'b0;
                exp_fe   = 1'b0;
            end else if (q.size() > 0 && q[0].e == cyc) begin
                if (q[0].has_dv) begin
                    exp_dv   = 1'b1;
                    exp_data = q[0].d;
                    exp_pe   = q[0].pe;
                    exp_fe   = q[0].fe;
                end
                void'(q.pop_front());
            end
            exp_busy = 1'b0;
            foreach (q[i]) if (q[i].s + 2 <= cyc && cyc < q[i].e) exp_busy = 1'b1;
            chk("DataValid", bus.DataValid, exp_dv);
            chk("Busy", bus.Busy, exp_busy);
            chk("Data", bus.Data, exp_data);
            chk("ParityError", bus.ParityError, exp_pe);
            chk("FramingError", bus.FramingError, exp_fe);
            if (bus.DataValid === 1'b1) begin
                dv_cnt++;
                last_dv_cyc = cyc;
                cap_data    = bus.Data;
                cap_pe      = bus.ParityError;
                cap_fe      = bus.FramingError;
            end
        end
    end

    initial begin
        int s0, c0;
        Reset      = 1'b0;
        bus.Rx     = 1'b1;
        bus.Speed  = 4'd8;
        bus.Parity = 1'b0;
        tick(3);
        Reset = 1'b1;
        chk("rst_data", bus.Data, 0);
        chk("rst_dv", bus.DataValid, 0);
        chk("rst_busy", bus.Busy, 0);
        chk("rst_pe", bus.ParityError, 0);
        chk("rst_fe", bus.FramingError, 0);
        tick(2);
        s0 = cyc + 1;
        send_frame(9'h1A5, 1'b1, 1'b1, -1);
        tick(4);
        chk("t1_dv_edge", last_dv_cyc - s0, 94);
        chk("t1_dv_count", dv_cnt, 1);
        chk("t1_data", cap_data, 9'h1A5);
        chk("t1_pe", cap_pe, 0);
        chk("t1_fe", cap_fe, 0);
        send_frame(9'h1A5, 1'b0, 1'b1, -1);
        tick(4);
        chk("t2_data", cap_data, 9'h1A5);
        chk("t2_pe", cap_pe, 1);
        bus.Parity = 1'b1;
        send_frame(9'h1A5, 1'b0, 1'b1, -1);
        tick(4);
        chk("t3_pe_odd", cap_pe, 0);
        bus.Parity = 1'b0;
        send_frame(9'h055, 1'b0, 1'b0, -1);
        tick(4);
        chk("t4_dv_count", dv_cnt, 4);
        chk("t4_data", cap_data, 9'h055);
        chk("t4_fe", cap_fe, 1);
        chk("t4_pe", cap_pe, 0);
        c0 = dv_cnt;
        glitch();
        tick(110);
`ifdef UART_RX_START_VERIFY_EN
        chk("glitch_no_dv", dv_cnt, c0);
        chk("glitch_data_kept", bus.Data, 9'h055);
`else
        chk("glitch_dv", dv_cnt, c0 + 1);
        chk("glitch_data", cap_data, 9'h1FF);
        chk("glitch_pe", cap_pe, 0);
        chk("glitch_fe", cap_fe, 0);
`endif
        bus.Speed  = 4'd15;
        bus.Parity = 1'b1;
        c0 = dv_cnt;
        send_frame(9'h000, 1'b1, 1'b1, -1);
        send_frame(9'h1FF, 1'b0, 1'b1, -1);
        send_frame(9'h12C, 1'b1, 1'b1, -1);
        tick(8);
        chk("loop_dv_count", dv_cnt, c0 + 3);
        chk("loop_data", cap_data, 9'h12C);
        chk("loop_pe", cap_pe, 0);
        chk("loop_fe", cap_fe, 0);
        bus.Speed  = 4'd4;
        bus.Parity = 1'b0;
        tick(2);
        send_frame(9'h0F0, 1'b0, 1'b1, 20);
        chk("rst2_data", bus.Data, 0);
        chk("rst2_busy", bus.Busy, 0);
        chk("rst2_dv", bus.DataValid, 0);
        tick(3);
        c0 = dv_cnt;
        s0 = cyc + 1;
        send_frame(9'h0F0, 1'b0, 1'b1, -1);
        tick(4);
        chk("rst2_rx_dv", dv_cnt, c0 + 1);
        chk("rst2_rx_edge", last_dv_cyc - s0, 48);
        chk("rst2_rx_data", cap_data, 9'h0F0);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
